// File: rtl/seq_serializer_if.sv
// Upstream word handshake for the parallel-to-serial stage.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and
// emits one registered bit per clock, gapless across back-to-back words.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_serializer_if.slave in_if,
    output logic            dout,
    output logic            dout_valid,
    output logic            busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             last;
    logic             rdy;
    logic             load;

    assign last        = (cnt == LAST);
    assign busy        = (state == SHIFT);
    // ready is suppressed while reset is held so no word is accepted then
    assign in_if.in_ready = rst_n & rdy;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, ready and load decision
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (in_if.in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    rdy = 1'b1;
                    if (in_if.in_valid) load      = 1'b1;
                    else                state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift datapath: first bit goes straight to dout on load, the rest
    // of the word waits in sreg and is shifted out one bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sreg       <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
        end else if (load) begin
            cnt        <= '0;
            dout_valid <= 1'b1;
            if (MSB_FIRST) begin
                dout <= in_if.in_data[WIDTH-1];
                sreg <= {in_if.in_data[WIDTH-2:0], 1'b0};
            end else begin
                dout <= in_if.in_data[0];
                sreg <= {1'b0, in_if.in_data[WIDTH-1:1]};
            end
        end else if (state == SHIFT && !last) begin
            cnt <= cnt + CW'(1);
            if (MSB_FIRST) begin
                dout <= sreg[WIDTH-1];
                sreg <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
                dout <= sreg[0];
                sreg <= {1'b0, sreg[WIDTH-1:1]};
            end
        end else if (state == SHIFT) begin
            cnt        <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: a WIDTH=8 MSB-first instance driven
// from a per-cycle vector table, and a WIDTH=5 LSB-first instance driven
// by a short hand-written sequence. A 10110 detector model watches each
// serial stream.
module tb_seq_serializer;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_serializer_if #(.WIDTH(8)) a_if ();
    seq_serializer_if #(.WIDTH(5)) b_if ();

    logic a_dout, a_dv, a_busy;
    logic b_dout, b_dv, b_busy;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_if(a_if),
        .dout(a_dout), .dout_valid(a_dv), .busy(a_busy)
    );

    seq_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_if(b_if),
        .dout(b_dout), .dout_valid(b_dv), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Non-overlapping 10110 detector models fed by the valid serial bits
    int       det_a = 0, det_b = 0;
    logic [4:0] hist_a = '0, hist_b = '0;
    int       len_a = 0, len_b = 0;

    always @(negedge clk) begin
        logic [4:0] h;
        if (a_dv) begin
            h = {hist_a[3:0], a_dout};
            len_a = len_a + 1;
            if (len_a >= 5 && h == 5'b10110) begin
                det_a = det_a + 1;
                len_a = 0;
            end
            hist_a = h;
        end else begin
            len_a = 0;
        end
        if (b_dv) begin
            h = {hist_b[3:0], b_dout};
            len_b = len_b + 1;
            if (len_b >= 5 && h == 5'b10110) begin
                det_b = det_b + 1;
                len_b = 0;
            end
            hist_b = h;
        end else begin
            len_b = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       dout;
        logic       dv;
        logic       rdy;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [7:0] d,
                                input logic o, input logic dv,
                                input logic r, input logic b);
        vec_t e;
        e.vld = v; e.data = d; e.dout = o; e.dv = dv; e.rdy = r; e.busy = b;
        tbl.push_back(e);
    endfunction

    // Apply rows [first, last_row): drive, clock, then compare all outputs
    task automatic run_rows(input int first, input int last_row);
        for (int i = first; i < last_row; i++) begin
            a_if.in_valid = tbl[i].vld;
            a_if.in_data  = tbl[i].data;
            @(posedge clk);
            #1;
            check($sformatf("row%0d dout", i),     int'(a_dout),          int'(tbl[i].dout));
            check($sformatf("row%0d valid", i),    int'(a_dv),            int'(tbl[i].dv));
            check($sformatf("row%0d in_ready", i), int'(a_if.in_ready),   int'(tbl[i].rdy));
            check($sformatf("row%0d busy", i),     int'(a_busy),          int'(tbl[i].busy));
        end
        a_if.in_valid = 1'b0;
    endtask

    int p1, p2, p3, p4;
    int det_before;
    logic [4:0] b_exp;

    initial begin
        // Single word 8'b1011_0000
        add(1, 8'hB0, 1, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 1, 1);
        add(0, 8'h00, 0, 0, 1, 0);
        p1 = tbl.size();
        // Back-to-back B6 then C0, C0 held (stalled) while B6 shifts
        add(1, 8'hB6, 1, 1, 0, 1);
        add(1, 8'hC0, 0, 1, 0, 1);
        add(1, 8'hC0, 1, 1, 0, 1);
        add(1, 8'hC0, 1, 1, 0, 1);
        add(1, 8'hC0, 0, 1, 0, 1);
        add(1, 8'hC0, 1, 1, 0, 1);
        add(1, 8'hC0, 1, 1, 0, 1);
        add(1, 8'hC0, 0, 1, 1, 1);
        add(1, 8'hC0, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 1, 1);
        add(0, 8'h00, 0, 0, 1, 0);
        p2 = tbl.size();
        // 8'hFF up to bit 3, then reset hits
        add(1, 8'hFF, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        p3 = tbl.size();
        // 8'h0F after reset release
        add(1, 8'h0F, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 1);
        add(0, 8'h00, 1, 1, 1, 1);
        add(0, 8'h00, 0, 0, 1, 0);
        p4 = tbl.size();

        rst_n = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_data = '0;
        b_if.in_valid = 1'b0; b_if.in_data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst dout",     int'(a_dout),        0);
        check("rst valid",    int'(a_dv),          0);
        check("rst busy",     int'(a_busy),        0);
        check("rst in_ready", int'(a_if.in_ready), 0);
        check("rst b_ready",  int'(b_if.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", int'(a_if.in_ready), 1);
        @(negedge clk);

        // Single word; 10110000 contains one pattern
        det_before = det_a;
        run_rows(0, p1);
        @(negedge clk); #1;
        check("det single word", det_a - det_before, 1);

        // Back-to-back with stall; two detections incl. word-boundary one
        det_before = det_a;
        run_rows(p1, p2);
        @(negedge clk); #1;
        check("det back-to-back", det_a - det_before, 2);

        // Reset mid-word: outputs clear before the next edge
        run_rows(p2, p3);
        rst_n = 1'b0;
        #1;
        check("midrst valid",    int'(a_dv),          0);
        check("midrst dout",     int'(a_dout),        0);
        check("midrst busy",     int'(a_busy),        0);
        check("midrst in_ready", int'(a_if.in_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_rows(p3, p4);

        // LSB-first WIDTH=5, 5'b01101 -> 1,0,1,1,0
        det_before = det_b;
        @(negedge clk);
        b_if.in_valid = 1'b1;
        b_if.in_data  = 5'b01101;
        b_exp = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            b_if.in_valid = 1'b0;
            check($sformatf("lsb bit%0d dout", i), int'(b_dout), int'(b_exp[i]));
            check($sformatf("lsb bit%0d valid", i), int'(b_dv), 1);
        end
        @(posedge clk);
        #1;
        check("lsb end valid", int'(b_dv),   0);
        check("lsb end dout",  int'(b_dout), 0);
        check("lsb end busy",  int'(b_busy), 0);
        @(negedge clk); #1;
        check("det lsb", det_b - det_before, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
